regfile_scb: RTL



---
 rtl/regfile_pkg.sv | 21 ++
 rtl/regfile_scb_bypass.sv | 54 +++++
 rtl/regfile_scb.sv | 129 ++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// ============================================================================
// Module      : regfile_pkg
// Description : Shared register-file types and defaults for decode/writeback.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int AW_DEF   = $clog2(NREG_DEF);

    typedef logic [AW_DEF-1:0] reg_addr_t;

    // Hard-wired zero register: never written, never busy.
    localparam reg_addr_t ZERO_REG = '0;

endpackage : regfile_pkg

`default_nettype wire

// File: rtl/regfile_scb_bypass.sv
// ============================================================================
// Module      : regfile_scb_bypass
// Description : One read port: zero-register, write-bypass and array mux.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_scb_bypass
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NWP  = 2,
    parameter int AW   = AW_DEF
) (
    input  logic [AW-1:0]       raddr,
    input  logic [NWP-1:0]      we,
    input  logic [NWP*AW-1:0]   waddr,
    input  logic [NWP*XLEN-1:0] wdata,
    input  logic [XLEN-1:0]     arr_data,
    input  logic                busy,
    output logic [XLEN-1:0]     rdata,
    output logic                rready
);

    logic            w_hit;
    logic [XLEN-1:0] w_byp_data;

    // Ascending scan so the highest-index matching write port wins.
    always_comb begin
        w_hit      = 1'b0;
        w_byp_data = '0;
        for (int j = 0; j < NWP; j++) begin
            if (we[j] && (waddr[j*AW +: AW] == raddr)) begin
                w_hit      = 1'b1;
                w_byp_data = wdata[j*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        rdata  = arr_data;
        rready = ~busy;
        if (raddr == AW'(ZERO_REG)) begin
            rdata  = '0;
            rready = 1'b1;
        end else if (w_hit) begin
            rdata  = w_byp_data;
            rready = 1'b1;
        end
    end

endmodule : regfile_scb_bypass

`default_nettype wire

// File: rtl/regfile_scb.sv
// ============================================================================
// Module      : regfile_scb
// Description : Multi-port register file with write bypass and busy scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_scb
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NRP  = 2,
    parameter int NWP  = 2,
    localparam int AW  = $clog2(NREG),
    localparam int CW  = $clog2(NREG + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRP*AW-1:0]   raddr,
    output logic [NRP*XLEN-1:0] rdata,
    output logic [NRP-1:0]      rready,
    input  logic [NWP-1:0]      we,
    input  logic [NWP*AW-1:0]   waddr,
    input  logic [NWP*XLEN-1:0] wdata,
    input  logic                alloc_v,
    input  logic [AW-1:0]       alloc_rd,
    input  logic                flush,
    output logic [CW-1:0]       busy_cnt
);

    logic [XLEN-1:0] r_mem [NREG];
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;
    logic [NREG-1:0] w_release;
    logic [CW-1:0]   r_busy_cnt;
    logic [CW-1:0]   w_busy_pop;

    // ------------------------------------------------------------------
    // Storage array; later write ports override earlier ones on conflict.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                r_mem[r] <= '0;
            end
        end else begin
            for (int j = 0; j < NWP; j++) begin
                if (we[j] && (waddr[j*AW +: AW] != AW'(ZERO_REG))) begin
                    r_mem[waddr[j*AW +: AW]] <= wdata[j*XLEN +: XLEN];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard next state: alloc > flush > release > hold.
    // ------------------------------------------------------------------
    always_comb begin
        w_release = '0;
        for (int j = 0; j < NWP; j++) begin
            if (we[j]) begin
                w_release[waddr[j*AW +: AW]] = 1'b1;
            end
        end
    end

    always_comb begin
        w_busy_nxt = r_busy;
        for (int r = 1; r < NREG; r++) begin
            if (alloc_v && (alloc_rd == AW'(r))) begin
                w_busy_nxt[r] = 1'b1;
            end else if (flush) begin
                w_busy_nxt[r] = 1'b0;
            end else if (w_release[r]) begin
                w_busy_nxt[r] = 1'b0;
            end
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_comb begin
        w_busy_pop = '0;
        for (int r = 0; r < NREG; r++) begin
            w_busy_pop = w_busy_pop + CW'(w_busy_nxt[r]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_busy_cnt <= w_busy_pop;
        end
    end

    assign busy_cnt = r_busy_cnt;

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NRP; i++) begin : g_rport
        logic [AW-1:0]   w_addr;
        logic [XLEN-1:0] w_arr_data;

        assign w_addr     = raddr[i*AW +: AW];
        assign w_arr_data = r_mem[w_addr];

        regfile_scb_bypass #(
            .XLEN (XLEN),
            .NWP  (NWP),
            .AW   (AW)
        ) u_bypass (
            .raddr    (w_addr),
            .we       (we),
            .waddr    (waddr),
            .wdata    (wdata),
            .arr_data (w_arr_data),
            .busy     (r_busy[w_addr]),
            .rdata    (rdata[i*XLEN +: XLEN]),
            .rready   (rready[i])
        );
    end : g_rport

endmodule : regfile_scb

`default_nettype wire
